// File: rtl/mips_writeback_queue.sv
// mips_writeback_queue: in-order writeback buffer feeding two reg-file write ports.
// Optional `define WB_BYPASS_EN adds per-query forwarding outputs (bypass_valid/data).
module mips_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_en_a,
    input  logic                         in_en_b,
    input  logic [ADDR_W-1:0]            in_reg_a,
    input  logic [ADDR_W-1:0]            in_reg_b,
    input  logic [DATA_W-1:0]            in_data_a,
    input  logic [DATA_W-1:0]            in_data_b,
    input  logic                         wb_stall,
    output logic [ADDR_W-1:0]            write_reg,
    output logic [DATA_W-1:0]            write_data,
    output logic                         signal_reg_write,
    output logic [ADDR_W-1:0]            write_reg2,
    output logic [DATA_W-1:0]            write_data2,
    output logic                         signal_reg_write2,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    input  logic [ADDR_W-1:0]            busy_query_1,
    input  logic [ADDR_W-1:0]            busy_query_2,
    output logic                         busy_1,
    output logic                         busy_2
`ifdef WB_BYPASS_EN
    ,
    output logic                         bypass_valid_1,
    output logic                         bypass_valid_2,
    output logic [DATA_W-1:0]            bypass_data_1,
    output logic [DATA_W-1:0]            bypass_data_2
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              en_a;
        logic              en_b;
        logic [ADDR_W-1:0] reg_a;
        logic [ADDR_W-1:0] reg_b;
        logic [DATA_W-1:0] data_a;
        logic [DATA_W-1:0] data_b;
    } entry_t;

    entry_t             mem_q [DEPTH];
    logic [DEPTH-1:0]   valid_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q, count_d;
    entry_t             out_q;

    entry_t             in_entry;
    logic               push, store, pop;

    // Filter the incoming packet: r0 is never written, and B wins a same-register pair
    always_comb begin
        in_entry        = '0;
        in_entry.reg_a  = in_reg_a;
        in_entry.reg_b  = in_reg_b;
        in_entry.data_a = in_data_a;
        in_entry.data_b = in_data_b;
        in_entry.en_b   = in_en_b && (in_reg_b != '0);
        in_entry.en_a   = in_en_a && (in_reg_a != '0) &&
                          !(in_entry.en_b && (in_reg_a == in_reg_b));
    end

    assign in_ready = (count_q != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign store    = push && (in_entry.en_a || in_entry.en_b);
    assign pop      = (count_q != '0) && !wb_stall;
    assign count_d  = count_q + CNT_W'(store) - CNT_W'(pop);

    // Payload storage; validity is tracked separately so no reset is needed here
    always_ff @(posedge clk) begin
        if (store)
            mem_q[wr_ptr_q] <= in_entry;
    end

    // Pointers, occupancy and the registered write-port stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= '0;
            out_q    <= '0;
        end else begin
            count_q <= count_d;
            if (store) begin
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
                out_q             <= mem_q[rd_ptr_q];
            end else begin
                out_q.en_a <= 1'b0;
                out_q.en_b <= 1'b0;
            end
        end
    end

    assign count             = count_q;
    assign write_reg         = out_q.reg_a;
    assign write_data        = out_q.data_a;
    assign signal_reg_write  = out_q.en_a;
    assign write_reg2        = out_q.reg_b;
    assign write_data2       = out_q.data_b;
    assign signal_reg_write2 = out_q.en_b;

    function automatic logic hit(input entry_t e, input logic [ADDR_W-1:0] q);
        return (e.en_a && (e.reg_a == q)) || (e.en_b && (e.reg_b == q));
    endfunction

    // Interlock: any pending write (queued or on the ports now) to a queried register
    always_comb begin
        busy_1 = hit(out_q, busy_query_1);
        busy_2 = hit(out_q, busy_query_2);
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && hit(mem_q[i], busy_query_1)) busy_1 = 1'b1;
            if (valid_q[i] && hit(mem_q[i], busy_query_2)) busy_2 = 1'b1;
        end
        if (busy_query_1 == '0) busy_1 = 1'b0;
        if (busy_query_2 == '0) busy_2 = 1'b0;
    end

`ifdef WB_BYPASS_EN
    logic [PTR_W-1:0] idx;

    // Forward the youngest value: walk oldest to youngest so later matches win
    always_comb begin
        idx           = '0;
        bypass_data_1 = '0;
        bypass_data_2 = '0;
        if (out_q.en_a && out_q.reg_a == busy_query_1) bypass_data_1 = out_q.data_a;
        if (out_q.en_b && out_q.reg_b == busy_query_1) bypass_data_1 = out_q.data_b;
        if (out_q.en_a && out_q.reg_a == busy_query_2) bypass_data_2 = out_q.data_a;
        if (out_q.en_b && out_q.reg_b == busy_query_2) bypass_data_2 = out_q.data_b;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PTR_W'(k);
            if (valid_q[idx]) begin
                if (mem_q[idx].en_a && mem_q[idx].reg_a == busy_query_1)
                    bypass_data_1 = mem_q[idx].data_a;
                if (mem_q[idx].en_b && mem_q[idx].reg_b == busy_query_1)
                    bypass_data_1 = mem_q[idx].data_b;
                if (mem_q[idx].en_a && mem_q[idx].reg_a == busy_query_2)
                    bypass_data_2 = mem_q[idx].data_a;
                if (mem_q[idx].en_b && mem_q[idx].reg_b == busy_query_2)
                    bypass_data_2 = mem_q[idx].data_b;
            end
        end
        bypass_valid_1 = busy_1;
        bypass_valid_2 = busy_2;
    end
`endif

endmodule

// File: tb/tb_mips_writeback_queue.sv
// tb_mips_writeback_queue: table-driven check of mips_writeback_queue
// plus directed reset, busy and (with WB_BYPASS_EN) forwarding sequences.
module tb_mips_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_en_a, in_en_b, wb_stall;
    logic [4:0]  in_reg_a, in_reg_b;
    logic [31:0] in_data_a, in_data_b;
    logic [4:0]  write_reg, write_reg2;
    logic [31:0] write_data, write_data2;
    logic        signal_reg_write, signal_reg_write2;
    logic [2:0]  count;
    logic [4:0]  busy_query_1, busy_query_2;
    logic        busy_1, busy_2;
`ifdef WB_BYPASS_EN
    logic        bypass_valid_1, bypass_valid_2;
    logic [31:0] bypass_data_1, bypass_data_2;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mips_writeback_queue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_en_a(in_en_a), .in_en_b(in_en_b),
        .in_reg_a(in_reg_a), .in_reg_b(in_reg_b),
        .in_data_a(in_data_a), .in_data_b(in_data_b),
        .wb_stall(wb_stall),
        .write_reg(write_reg), .write_data(write_data),
        .signal_reg_write(signal_reg_write),
        .write_reg2(write_reg2), .write_data2(write_data2),
        .signal_reg_write2(signal_reg_write2),
        .count(count),
        .busy_query_1(busy_query_1), .busy_query_2(busy_query_2),
        .busy_1(busy_1), .busy_2(busy_2)
`ifdef WB_BYPASS_EN
        ,
        .bypass_valid_1(bypass_valid_1), .bypass_valid_2(bypass_valid_2),
        .bypass_data_1(bypass_data_1), .bypass_data_2(bypass_data_2)
`endif
    );

    typedef struct {
        logic        v, ea, eb;
        logic [4:0]  ra, rb;
        logic [31:0] da, db;
        logic        st;
        logic [2:0]  cnt;
        logic        rdy, w1;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        w2;
        logic [4:0]  r2;
        logic [31:0] d2;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic v, ea, eb, input logic [4:0] ra, rb,
        input logic [31:0] da, db, input logic st,
        input logic [2:0] cnt, input logic rdy, w1, input logic [4:0] r1,
        input logic [31:0] d1, input logic w2, input logic [4:0] r2,
        input logic [31:0] d2);
        vec_t t;
        t.v = v; t.ea = ea; t.eb = eb; t.ra = ra; t.rb = rb;
        t.da = da; t.db = db; t.st = st; t.cnt = cnt; t.rdy = rdy;
        t.w1 = w1; t.r1 = r1; t.d1 = d1; t.w2 = w2; t.r2 = r2; t.d2 = d2;
        return t;
    endfunction

    // Packet k of the fill/stream tests: A=r(k+1), B=r(k+11)
    function automatic logic [4:0]  pa(input int k); return 5'(k + 1);  endfunction
    function automatic logic [4:0]  pb(input int k); return 5'(k + 11); endfunction
    function automatic logic [31:0] pda(input int k); return 32'hA000 + 32'(k); endfunction
    function automatic logic [31:0] pdb(input int k); return 32'hB000 + 32'(k); endfunction

    task automatic drive(input vec_t t);
        in_valid = t.v; in_en_a = t.ea; in_en_b = t.eb;
        in_reg_a = t.ra; in_reg_b = t.rb;
        in_data_a = t.da; in_data_b = t.db; wb_stall = t.st;
    endtask

    task automatic idle_in();
        in_valid = 0; in_en_a = 0; in_en_b = 0;
        in_reg_a = 0; in_reg_b = 0; in_data_a = 0; in_data_b = 0;
    endtask

    task automatic push_pk(input int k);
        in_valid = 1; in_en_a = 1; in_en_b = 1;
        in_reg_a = pa(k); in_reg_b = pb(k);
        in_data_a = pda(k); in_data_b = pdb(k);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [79:0] act, exp;
        idle_in();
        wb_stall = 0;
        busy_query_1 = 0;
        busy_query_2 = 0;
        rst_n = 0;

        // ---- vector table ----
        vt.push_back(mk(1,1,0, 5,0, 32'h1234,0, 0, 1,1,0,0,0, 0,0,0));
        vt.push_back(mk(0,0,0, 0,0, 0,0, 0, 0,1,1,5,32'h1234, 0,0,0));
        vt.push_back(mk(0,0,0, 0,0, 0,0, 0, 0,1,0,5,32'h1234, 0,0,0));
        vt.push_back(mk(1,1,1, 0,7, 32'h11,32'h77, 0, 1,1,0,5,32'h1234, 0,0,0));
        vt.push_back(mk(1,1,1, 9,9, 32'h99,32'h98, 0, 1,1,0,0,32'h11, 1,7,32'h77));
        vt.push_back(mk(1,1,1, 0,0, 32'h55,32'h66, 0, 0,1,0,9,32'h99, 1,9,32'h98));
        vt.push_back(mk(0,0,0, 0,0, 0,0, 0, 0,1,0,9,32'h99, 0,9,32'h98));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(1,1,1, pa(k),pb(k), pda(k),pdb(k), 1,
                            3'(k+1), k < 3, 0,9,32'h99, 0,9,32'h98));
        vt.push_back(mk(1,1,1, pa(9),pb(9), pda(9),pdb(9), 1,
                        4,0,0,9,32'h99, 0,9,32'h98));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(0,0,0, 0,0, 0,0, 0, 3'(3-k),1,
                            1,pa(k),pda(k), 1,pb(k),pdb(k)));
        vt.push_back(mk(0,0,0, 0,0, 0,0, 0, 0,1, 0,pa(3),pda(3), 0,pb(3),pdb(3)));
        vt.push_back(mk(1,1,1, pa(4),pb(4), pda(4),pdb(4), 1,
                        1,1, 0,pa(3),pda(3), 0,pb(3),pdb(3)));
        vt.push_back(mk(1,1,1, pa(5),pb(5), pda(5),pdb(5), 1,
                        2,1, 0,pa(3),pda(3), 0,pb(3),pdb(3)));
        for (int j = 0; j < 10; j++)
            vt.push_back(mk(1,1,1, pa(6+j),pb(6+j), pda(6+j),pdb(6+j), 0,
                            2,1, 1,pa(4+j),pda(4+j), 1,pb(4+j),pdb(4+j)));
        vt.push_back(mk(0,0,0, 0,0, 0,0, 0, 1,1, 1,pa(14),pda(14), 1,pb(14),pdb(14)));
        vt.push_back(mk(0,0,0, 0,0, 0,0, 0, 0,1, 1,pa(15),pda(15), 1,pb(15),pdb(15)));
        vt.push_back(mk(0,0,0, 0,0, 0,0, 0, 0,1, 0,pa(15),pda(15), 0,pb(15),pdb(15)));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", 32'(count), 0);
        chk("reset_ready", 32'(in_ready), 1);
        chk("reset_we", {30'b0, signal_reg_write, signal_reg_write2}, 0);
        @(negedge clk);
        rst_n = 1;

        foreach (vt[i]) begin
            drive(vt[i]);
            step();
            act = {count, in_ready, signal_reg_write, write_reg, write_data,
                   signal_reg_write2, write_reg2, write_data2};
            exp = {vt[i].cnt, vt[i].rdy, vt[i].w1, vt[i].r1, vt[i].d1,
                   vt[i].w2, vt[i].r2, vt[i].d2};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL vec%0d: got %h expected %h", i, act, exp);
            end
        end
        idle_in();
        wb_stall = 0;

        // ---- async reset mid-stream with 3 entries ----
        wb_stall = 1;
        for (int k = 0; k < 3; k++) begin
            push_pk(k);
            step();
        end
        idle_in();
        chk("rst_pre_count", 32'(count), 3);
        wb_stall = 0;
        step();
        busy_query_1 = pa(1);
        #1;
        chk("rst_pre_we1", 32'(signal_reg_write), 1);
        chk("rst_pre_busy", 32'(busy_1), 1);
        #1;
        rst_n = 0;
        #1;
        chk("rst_count", 32'(count), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_we", {30'b0, signal_reg_write, signal_reg_write2}, 0);
        chk("rst_busy", 32'(busy_1), 0);
        @(negedge clk);
        rst_n = 1;

        // ---- single write, busy window ----
        busy_query_1 = 5;
        busy_query_2 = 5;
        @(negedge clk);
        chk("busy_before", {30'b0, busy_1, busy_2}, 0);
        in_valid = 1; in_en_a = 1; in_reg_a = 5; in_data_a = 32'h1234;
        step();
        idle_in();
        chk("busy_queued", {30'b0, busy_1, busy_2}, 3);
        chk("single_we_early", 32'(signal_reg_write), 0);
        step();
        chk("single_we", 32'(signal_reg_write), 1);
        chk("single_reg", 32'(write_reg), 5);
        chk("single_data", write_data, 32'h1234);
        chk("busy_out", 32'(busy_1), 1);
        step();
        chk("busy_after", {30'b0, busy_1, busy_2}, 0);
        busy_query_2 = 0;
        #1;
        chk("busy_r0", 32'(busy_2), 0);

`ifdef WB_BYPASS_EN
        // ---- youngest-value forwarding ----
        wb_stall = 1;
        in_valid = 1; in_en_a = 1; in_reg_a = 3; in_data_a = 32'hA;
        step();
        in_en_a = 0; in_en_b = 1; in_reg_b = 3; in_data_b = 32'hB;
        step();
        idle_in();
        busy_query_1 = 3;
        busy_query_2 = 3;
        #1;
        chk("byp_q_valid", {30'b0, bypass_valid_1, bypass_valid_2}, 3);
        chk("byp_q_data1", bypass_data_1, 32'hB);
        chk("byp_q_data2", bypass_data_2, 32'hB);
        wb_stall = 0;
        step();
        chk("byp_mid_valid", 32'(bypass_valid_1), 1);
        chk("byp_mid_data", bypass_data_1, 32'hB);
        step();
        chk("byp_out_valid", 32'(bypass_valid_1), 1);
        chk("byp_out_data", bypass_data_1, 32'hB);
        step();
        chk("byp_done_valid", {30'b0, bypass_valid_1, bypass_valid_2}, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
